fractal_pixel_writer: RTL and testbench

//  Downstream stage of the fractal calculator.
//  - Accepts computed pixels (x_draw, y_draw, intensity) over a valid/ready handshake.
//  - Buffers them in a small FIFO.
//  - Clamps intensity, maps it to an 8-bit grey level and writes it to frame memory at y*IMG_W+x.
//  - Counts written pixels and pulses frame_done when a full frame has been stored.

---
 rtl/fractal_pixel_writer.sv | 142 ++++++++++++++
 tb/tb_fractal_pixel_writer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_pixel_writer.sv
// fractal_pixel_writer: buffers computed fractal pixels and writes clamped grey levels to frame memory
module fractal_pixel_writer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               frame_start,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic signed [15:0] x_draw,
    input  logic signed [15:0] y_draw,
    input  logic [7:0]         intensity,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_data,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic [ADDR_W-1:0]  pixel_count,
    output logic               frame_done,
    output logic               oob_err,
    output logic               busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] TOTAL = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic signed [15:0] X_LIM = 16'(IMG_W);
    localparam logic signed [15:0] Y_LIM = 16'(IMG_H);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    state_t state;

    logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              fifo_full, fifo_empty, in_range, push, push_ok, pop;
    logic              skip, counting, to_done;
    logic [6:0]        ic;
    logic [ADDR_W-1:0] pix_addr, head_addr;
    logic [7:0]        pix_grey, head_grey;

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pix_ready  = RESET && !fifo_full && !frame_start;
    assign push       = pix_valid && pix_ready;
    assign in_range   = !x_draw[15] && !y_draw[15] && (x_draw < X_LIM) && (y_draw < Y_LIM);
    assign push_ok    = push && in_range;

    // Grey level and address are resolved before queueing so the write side only moves data
    assign ic       = (intensity > 8'd100) ? 7'd100 : intensity[6:0];
    assign pix_grey = 8'(({9'd0, ic} * 16'd655) >> 8);
    assign pix_addr = ADDR_W'(y_draw[15:0]) * ADDR_W'(IMG_W) + ADDR_W'(x_draw[15:0]);

    assign {head_addr, head_grey} = fifo_mem[rd_ptr[PW-1:0]];

    // A write in flight when frame_start arrives belongs to the old frame and is never counted
    assign counting = !skip && (pixel_count != TOTAL);
    assign to_done  = counting && (pixel_count == LAST);
    assign pop      = !frame_start && !fifo_empty &&
                      ((state == IDLE) || (state == WRITE && mem_ack && !to_done));
    assign busy     = !fifo_empty || (state != IDLE);

    // FIFO pointers; frame_start discards everything still queued
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (frame_start) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // FIFO storage of pre-computed {addr, grey}
    always_ff @(posedge CLK) begin
        if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= {pix_addr, pix_grey};
    end

    // Write sequencer: pop, present, hold until ack, count, flag frame completion
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            oob_err     <= 1'b0;
            skip        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                pixel_count <= '0;
                oob_err     <= 1'b0;
            end else if (push && !in_range) begin
                oob_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        mem_addr <= head_addr;
                        mem_data <= head_grey;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (frame_start) begin
                        state <= IDLE;
                    end else begin
                        mem_we <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        skip   <= 1'b0;
                        if (!frame_start && counting) pixel_count <= pixel_count + ADDR_W'(1);
                        if (!frame_start && to_done) begin
                            state <= DONE;
                        end else if (pop) begin
                            mem_addr <= head_addr;
                            mem_data <= head_grey;
                            state    <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (frame_start) begin
                        skip <= 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= !frame_start;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fractal_pixel_writer.sv
// tb_fractal_pixel_writer: table vectors, corner sequences and a randomized reference-model run
module tb_fractal_pixel_writer;
    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               frame_start = 1'b0, pix_valid = 1'b0, mem_ack = 1'b0;
    logic signed [15:0] x_draw = '0, y_draw = '0;
    logic [7:0]         intensity = '0;
    logic               pix_ready, mem_we, frame_done, oob_err, busy;
    logic [18:0]        mem_addr, pixel_count;
    logic [7:0]         mem_data;

    logic               s_start = 1'b0, s_valid = 1'b0, s_ack = 1'b0;
    logic signed [15:0] s_x = '0, s_y = '0;
    logic [7:0]         s_int = '0;
    logic               s_ready, s_we, s_fd, s_oob, s_busy;
    logic [18:0]        s_addr, s_cnt;
    logic [7:0]         s_data;

    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    fractal_pixel_writer u_dut (
        .CLK(CLK), .RESET(RESET), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .x_draw(x_draw), .y_draw(y_draw), .intensity(intensity),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
        .pixel_count(pixel_count), .frame_done(frame_done), .oob_err(oob_err), .busy(busy)
    );

    fractal_pixel_writer #(.IMG_W(4), .IMG_H(2)) u_small (
        .CLK(CLK), .RESET(RESET), .frame_start(s_start), .pix_valid(s_valid),
        .pix_ready(s_ready), .x_draw(s_x), .y_draw(s_y), .intensity(s_int),
        .mem_addr(s_addr), .mem_data(s_data), .mem_we(s_we), .mem_ack(s_ack),
        .pixel_count(s_cnt), .frame_done(s_fd), .oob_err(s_oob), .busy(s_busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grey(input int i);
        int c = (i > 100) ? 100 : i;
        return (c * 655) / 256;
    endfunction

    function automatic bit model_ok(input int x, input int y);
        return x >= 0 && x < 640 && y >= 0 && y < 480;
    endfunction

    task automatic send(input int x, input int y, input int i);
        int n = 0;
        pix_valid = 1'b1; x_draw = 16'(x); y_draw = 16'(y); intensity = 8'(i);
        @(negedge CLK);
        while (!pix_ready && n < 100) begin @(negedge CLK); n++; end
        check("send_accept", pix_ready, 1);
        @(posedge CLK); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_we();
        int n = 0;
        @(negedge CLK);
        while (!mem_we && n < 20) begin @(negedge CLK); n++; end
        check("we_timeout", mem_we, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (busy && n < 100) begin @(negedge CLK); n++; end
        check("idle_timeout", busy, 0);
        @(posedge CLK); #1;
    endtask

    task automatic s_send(input int x, input int y, input int i);
        int n = 0;
        s_valid = 1'b1; s_x = 16'(x); s_y = 16'(y); s_int = 8'(i);
        @(negedge CLK);
        while (!s_ready && n < 100) begin @(negedge CLK); n++; end
        check("s_send_accept", s_ready, 1);
        @(posedge CLK); #1;
        s_valid = 1'b0;
    endtask

    task automatic s_wait_idle();
        int n = 0;
        @(negedge CLK);
        while (s_busy && n < 100) begin @(negedge CLK); n++; end
        check("s_idle_timeout", s_busy, 0);
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    // Reference model for the random run: ordered list of expected writes, count and sticky error
    logic mon_en = 1'b0;
    int   qa[$], qg[$];
    int   m_cnt = 0;
    bit   m_oob = 1'b0;
    always @(negedge CLK) begin
        if (mon_en) begin
            check("rnd_count", pixel_count, m_cnt);
            check("rnd_oob", oob_err, m_oob);
            if (pix_valid && pix_ready) begin
                if (model_ok(x_draw, y_draw)) begin
                    qa.push_back(int'(y_draw) * 640 + int'(x_draw));
                    qg.push_back(model_grey(int'(intensity)));
                end else begin
                    m_oob = 1'b1;
                end
            end
            if (mem_we && mem_ack) begin
                if (qa.size() == 0) begin
                    check("rnd_extra_write", mem_we, 0);
                end else begin
                    check("rnd_addr", mem_addr, qa.pop_front());
                    check("rnd_data", mem_data, qg.pop_front());
                end
                m_cnt++;
            end
        end
    end

    int s_fd_cnt = 0, s_wr = 0;
    always @(negedge CLK) begin
        if (s_fd) s_fd_cnt++;
        if (s_we && s_ack) s_wr++;
    end

    typedef struct {
        int x; int y; int i;
        bit ok; int addr; int grey;
    } vec_t;
    vec_t tv[11];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt, acc, w;
        bit exp_oob, took;
        tv[0]  = '{0, 0, 0, 1'b1, 0, 0};
        tv[1]  = '{639, 479, 100, 1'b1, 307199, 255};
        tv[2]  = '{10, 1, 200, 1'b1, 650, 255};
        tv[3]  = '{-1, 5, 50, 1'b0, 0, 0};
        tv[4]  = '{7, 7, 1, 1'b1, 4487, 2};
        tv[5]  = '{5, 480, 50, 1'b0, 0, 0};
        tv[6]  = '{1, 0, 99, 1'b1, 1, 253};
        tv[7]  = '{640, 0, 10, 1'b0, 0, 0};
        tv[8]  = '{0, -3, 255, 1'b0, 0, 0};
        tv[9]  = '{100, 200, 255, 1'b1, 128100, 255};
        tv[10] = '{320, 240, 50, 1'b1, 153920, 127};

        #2 RESET = 1'b0;
        #10;
        check("rst_we", mem_we, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", pixel_count, 0);
        check("rst_done", frame_done, 0);
        check("rst_oob", oob_err, 0);
        check("rst_addr", mem_addr, 0);
        @(posedge CLK); #3 RESET = 1'b1;
        #1 check("rst_release_ready", pix_ready, 1);
        @(posedge CLK); #1;

        // first pixel latency: accepted at E0, mem_we after E2, counted after ack at E3
        mem_ack = 1'b1;
        pix_valid = 1'b1; x_draw = 16'(3); y_draw = 16'(2); intensity = 8'(50);
        @(posedge CLK); #1 pix_valid = 1'b0;
        check("lat_e0_we", mem_we, 0);
        check("lat_e0_busy", busy, 1);
        @(posedge CLK); #1 check("lat_e1_we", mem_we, 0);
        @(posedge CLK); #1;
        check("lat_e2_we", mem_we, 1);
        check("lat_addr", mem_addr, 1283);
        check("lat_data", mem_data, 127);
        check("lat_e2_count", pixel_count, 0);
        @(posedge CLK); #1;
        check("lat_e3_count", pixel_count, 1);
        check("lat_e3_we", mem_we, 0);

        exp_cnt = 1;
        exp_oob = 1'b0;
        for (int k = 0; k < 11; k++) begin
            send(tv[k].x, tv[k].y, tv[k].i);
            if (tv[k].ok) begin
                wait_we();
                check($sformatf("tv%0d_addr", k), mem_addr, tv[k].addr);
                check($sformatf("tv%0d_data", k), mem_data, tv[k].grey);
                exp_cnt++;
            end else begin
                exp_oob = 1'b1;
            end
            wait_idle();
            check($sformatf("tv%0d_count", k), pixel_count, exp_cnt);
            check($sformatf("tv%0d_oob", k), oob_err, exp_oob);
        end

        // backpressure: ack held low, only FIFO_DEPTH+1 pixels can be taken
        mem_ack = 1'b0;
        acc = 0;
        pix_valid = 1'b1; x_draw = 16'(10); y_draw = 16'(3); intensity = 8'(10);
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK); took = pix_valid && pix_ready;
            @(posedge CLK); #1;
            if (took) begin
                acc++;
                x_draw = 16'(10 + acc); intensity = 8'(acc * 20 + 10);
            end
        end
        check("bp_accepted", acc, 5);
        check("bp_ready", pix_ready, 0);
        check("bp_we", mem_we, 1);
        check("bp_addr_hold", mem_addr, 1930);
        check("bp_data_hold", mem_data, model_grey(10));
        check("bp_count", pixel_count, exp_cnt);
        pix_valid = 1'b0;
        mem_ack = 1'b1;
        w = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (mem_we && mem_ack) begin
                check($sformatf("bp_wr%0d_addr", w), mem_addr, 1930 + w);
                check($sformatf("bp_wr%0d_data", w), mem_data, model_grey(w * 20 + 10));
                w++;
            end
        end
        @(posedge CLK); #1;
        check("bp_writes", w, 5);
        exp_cnt += 5;
        check("bp_final_count", pixel_count, exp_cnt);

        // frame_start while a write is pending and three pixels are queued
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) send(20 + k, 4, 60);
        repeat (2) @(posedge CLK); #1;
        check("fs_pre_we", mem_we, 1);
        check("fs_pre_oob", oob_err, 1);
        frame_start = 1'b1;
        #1 check("fs_ready_blocked", pix_ready, 0);
        @(posedge CLK); #1 frame_start = 1'b0;
        check("fs_count", pixel_count, 0);
        check("fs_oob", oob_err, 0);
        check("fs_we_held", mem_we, 1);
        check("fs_addr_held", mem_addr, 2580);
        mem_ack = 1'b1;
        w = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (mem_we && mem_ack) w++;
        end
        @(posedge CLK); #1;
        check("fs_writes", w, 1);
        check("fs_post_count", pixel_count, 0);
        check("fs_post_busy", busy, 0);

        // asynchronous reset in the middle of a pending write
        send(1, 1, 50);
        wait_idle();
        check("ar_pre_count", pixel_count, 1);
        mem_ack = 1'b0;
        send(2, 1, 50);
        wait_we();
        #2 RESET = 1'b0;
        #1;
        check("ar_we", mem_we, 0);
        check("ar_busy", busy, 0);
        check("ar_count", pixel_count, 0);
        check("ar_ready", pix_ready, 0);
        @(posedge CLK); #3 RESET = 1'b1;
        @(posedge CLK); #1;
        mem_ack = 1'b1;
        send(5, 0, 100);
        wait_we();
        check("ar_post_addr", mem_addr, 5);
        check("ar_post_data", mem_data, 255);
        wait_idle();
        check("ar_post_count", pixel_count, 1);

        // randomized traffic against the reference model
        frame_start = 1'b1;
        @(posedge CLK); #1 frame_start = 1'b0;
        m_cnt = 0; m_oob = 1'b0;
        qa.delete(); qg.delete();
        mon_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK); took = pix_valid && pix_ready;
            @(posedge CLK); #1;
            if (took || !pix_valid) begin
                pix_valid = ($urandom_range(0, 3) != 0);
                x_draw = 16'(int'($urandom_range(0, 680)) - 10);
                y_draw = 16'(int'($urandom_range(0, 510)) - 10);
                intensity = 8'($urandom_range(0, 255));
            end
            mem_ack = ($urandom_range(0, 2) != 0);
        end
        pix_valid = 1'b0;
        mem_ack = 1'b1;
        wait_idle();
        @(negedge CLK); #1 mon_en = 1'b0;
        check("rnd_drained", qa.size(), 0);
        check("rnd_final_count", pixel_count, m_cnt);
        @(posedge CLK); #1;

        // small frame: completion pulse, saturation, writes continue afterwards
        s_ack = 1'b1;
        for (int k = 0; k < 8; k++) s_send(k % 4, k / 4, k * 30);
        s_wait_idle();
        check("sm_done_pulses", s_fd_cnt, 1);
        check("sm_count", s_cnt, 8);
        check("sm_writes", s_wr, 8);
        s_send(1, 1, 100);
        s_wait_idle();
        check("sm_extra_writes", s_wr, 9);
        check("sm_sat_count", s_cnt, 8);
        check("sm_no_extra_done", s_fd_cnt, 1);
        check("sm_extra_addr", s_addr, 5);
        check("sm_extra_data", s_data, 255);
        check("sm_oob", s_oob, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
